xalu_seq: RTL

Sequential controller that drives a single external 4-bit ALU slice to perform word-wide operations, one nibble per clock. Carries and shift bits are held in a register between nibble steps, so they ripple through time rather than through hardware. The block sits between the CPU datapath and the slice. It latches the operands, steps the slice over every nibble, and returns the assembled result with carry, zero, negative-zero and equality flags behind a start/busy/done handshake.

---
 rtl/xalu_seq_if.sv | 31 +++
 rtl/xalu_seq.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/xalu_seq_if.sv
// CPU-side bus of the nibble-serial ALU controller: operation request,
// handshake and the assembled result with its flags.
interface xalu_seq_if #(
    parameter int NIB = 4
);
    localparam int W = 4 * NIB;

    logic         start;
    logic [2:0]   op;
    logic         com;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         zero;
    logic         neg_zero;
    logic         equ;

    modport master (
        output start, op, com, cin, a, b,
        input  busy, done, result, cout, zero, neg_zero, equ
    );

    modport slave (
        input  start, op, com, cin, a, b,
        output busy, done, result, cout, zero, neg_zero, equ
    );
endinterface

// File: rtl/xalu_seq.sv
// Drives an external combinational 4-bit ALU slice over a W-bit word, one
// nibble per clock, rippling carries/shift bits through a register.
module xalu_seq #(
    parameter int NIB = 4
) (
    input  logic       clk,
    input  logic       rst,
    xalu_seq_if.slave  bus,
    output logic [3:0] s_a,
    output logic [3:0] s_b,
    output logic [2:0] s_f,
    output logic       s_ci_left,
    output logic       s_ci_right,
    output logic       s_com,
    input  logic [3:0] s_d,
    input  logic       s_co_left,
    input  logic       s_co_right,
    input  logic       s_equ
);
    localparam int W  = 4 * NIB;
    localparam int IW = $clog2(NIB);
    localparam logic [IW-1:0] LAST_IDX = IW'(NIB - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_SHL = 3'd7;

    logic [1:0]    state_q,    state_d;
    logic [W-1:0]  a_q,        a_d;
    logic [W-1:0]  b_q,        b_d;
    logic [2:0]    op_q,       op_d;
    logic          com_q,      com_d;
    logic          carry_q,    carry_d;
    logic          equ_acc_q,  equ_acc_d;
    logic [IW-1:0] idx_q,      idx_d;
    logic [W-1:0]  result_q,   result_d;
    logic          cout_q,     cout_d;
    logic          zero_q,     zero_d;
    logic          neg_zero_q, neg_zero_d;
    logic          equ_q,      equ_d;

    logic is_shr;
    logic last_nib;
    logic start_ok;
    logic run;

    assign is_shr   = (op_q == OP_SHR);
    assign last_nib = is_shr ? (idx_q == '0) : (idx_q == LAST_IDX);
    assign start_ok = bus.start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign run      = (state_q == ST_RUN);

    always_comb begin
        // NOTE: every _d starts from its _q so no path through this block
        // leaves a variable unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        com_d      = com_q;
        carry_d    = carry_q;
        equ_acc_d  = equ_acc_q;
        idx_d      = idx_q;
        result_d   = result_q;
        cout_d     = cout_q;
        zero_d     = zero_q;
        neg_zero_d = neg_zero_q;
        equ_d      = equ_q;

        case (state_q)
            ST_RUN: begin
                result_d[{idx_q, 2'b00} +: 4] = s_d;
                carry_d   = is_shr ? s_co_right : s_co_left;
                equ_acc_d = equ_acc_q & s_equ;
                if (last_nib) begin
                    state_d    = ST_DONE;
                    cout_d     = (op_q == OP_ADD || op_q == OP_SHL || op_q == OP_SHR)
                                 ? carry_d : 1'b0;
                    zero_d     = (result_d == '0);
                    neg_zero_d = &result_d;
                    equ_d      = equ_acc_d;
                end else begin
                    idx_d = is_shr ? idx_q - IW'(1) : idx_q + IW'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_IDLE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Only reachable from IDLE or DONE, so it never disturbs a running op.
        if (start_ok) begin
            state_d   = ST_RUN;
            a_d       = bus.a;
            b_d       = bus.b;
            op_d      = bus.op;
            com_d     = bus.com;
            carry_d   = bus.cin;
            equ_acc_d = 1'b1;
            idx_d     = (bus.op == OP_SHR) ? LAST_IDX : '0;
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            com_q      <= 1'b0;
            carry_q    <= 1'b0;
            equ_acc_q  <= 1'b0;
            idx_q      <= '0;
            result_q   <= '0;
            cout_q     <= 1'b0;
            zero_q     <= 1'b0;
            neg_zero_q <= 1'b0;
            equ_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            com_q      <= com_d;
            carry_q    <= carry_d;
            equ_acc_q  <= equ_acc_d;
            idx_q      <= idx_d;
            result_q   <= result_d;
            cout_q     <= cout_d;
            zero_q     <= zero_d;
            neg_zero_q <= neg_zero_d;
            equ_q      <= equ_d;
        end
    end

    // Slice is idle-quiet: all drive lines sit at 0 outside RUN.
    assign s_a        = run ? a_q[{idx_q, 2'b00} +: 4] : 4'd0;
    assign s_b        = run ? b_q[{idx_q, 2'b00} +: 4] : 4'd0;
    assign s_f        = run ? op_q : 3'd0;
    assign s_com      = run ? com_q : 1'b0;
    assign s_ci_right = run && !is_shr && carry_q;
    assign s_ci_left  = run && is_shr && carry_q;

    assign bus.busy     = run;
    assign bus.done     = (state_q == ST_DONE);
    assign bus.result   = result_q;
    assign bus.cout     = cout_q;
    assign bus.zero     = zero_q;
    assign bus.neg_zero = neg_zero_q;
    assign bus.equ      = equ_q;
endmodule
